// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and write-record type for the register-file write arbiter
package rf_arb_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int RF_NUM_REQ = 3;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or after ptr
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  // scan offsets from farthest to nearest so the nearest eligible index wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin sharing of the RF write port; RFARB_X0_DROP_EN drops x0 writes
module rf_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ    = RF_NUM_REQ,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          we,
  output logic [ADDR_WIDTH-1:0]         wa,
  output logic [DATA_WIDTH-1:0]         wd,
  output logic                          conflict
);
  localparam int PW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] x0, elig, drop, gnt;
  logic [PW-1:0] rr_ptr, idx;
  logic any, multi;
  // requesters whose write would land in x0 and can be acknowledged without the port
  always_comb begin
    x0 = '0;
`ifdef RFARB_X0_DROP_EN
    for (int i = 0; i < NUM_REQ; i++) x0[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0;
`endif
  end
  assign elig      = (rst || hold) ? '0 : req_valid & ~x0;
  assign drop      = (rst || hold) ? '0 : req_valid & x0;
  assign multi     = |(elig & (elig - 1'b1));
  assign req_ready = gnt | drop;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );
  // register the winning write and advance the pointer past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      conflict <= 1'b0;
    end else begin
      we       <= any;
      conflict <= multi;
      if (any) begin
        rr_ptr <= (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        wa     <= req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        wd     <= req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed and randomized checks of rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;
  import rf_arb_pkg::*;
  logic clk = 1'b0, rst = 1'b0, hold = 1'b0;
  logic [2:0] req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0] req_ready;
  logic we, conflict;
  logic [4:0] wa;
  logic [31:0] wd;
  rf_wr_t r[3];
  int ptr_m;
  logic [2:0] e_ready, e_elig;
  logic e_we, e_conf;
  logic [4:0] e_wa;
  logic [31:0] e_wd;
  logic [31:0] rf_dut[32];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .we(we), .wa(wa), .wd(wd), .conflict(conflict)
  );

  task automatic drive(input logic [2:0] vv, input logic hh, input logic rr);
    @(negedge clk);
    req_valid = vv;
    hold      = hh;
    rst       = rr;
    req_addr  = {r[2].addr, r[1].addr, r[0].addr};
    req_data  = {r[2].data, r[1].data, r[0].data};
    e_elig  = '0;
    e_ready = '0;
    if (!rr && !hh) begin
      for (int i = 0; i < 3; i++) begin
`ifdef RFARB_X0_DROP_EN
        if (vv[i] && r[i].addr == 5'd0) e_ready[i] = 1'b1;
        else e_elig[i] = vv[i];
`else
        e_elig[i] = vv[i];
`endif
      end
      for (int k = 0; k < 3; k++) begin
        if (e_elig[(ptr_m + k) % 3]) begin
          e_ready[(ptr_m + k) % 3] = 1'b1;
          break;
        end
      end
    end
    #1;
  endtask

  task automatic tick();
    int g = -1;
    for (int i = 0; i < 3; i++) if (e_elig[i] && e_ready[i]) g = i;
    if (rst) begin
      ptr_m = 0; e_we = 1'b0; e_wa = '0; e_wd = '0; e_conf = 1'b0;
    end else begin
      e_we   = (g >= 0);
      e_conf = ($countones(e_elig) >= 2);
      if (g >= 0) begin
        e_wa  = r[g].addr;
        e_wd  = r[g].data;
        ptr_m = (g + 1) % 3;
      end
    end
    @(posedge clk);
    #1;
    if (we === 1'b1) rf_dut[wa] = wd;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) r[i] = '{addr: 5'(i + 1), data: $urandom};
    for (int c = 0; c < 2; c++) begin
      drive(3'b111, 1'b0, 1'b1);
      tests++;
      if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
      tick();
    end
    tests++;
    if ({we, wa, wd, conflict} !== 39'd0)
      begin fails++; $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h conflict=%b exp all 0", we, wa, wd, conflict); end
    drive(3'b000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_single();
    r[1] = '{addr: 5'd5, data: 32'h1234};
    drive(3'b010, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b010) begin fails++; $display("FAIL single_ready: got %b exp 010", req_ready); end
    tick();
    tests++;
    if ({we, wa, wd, conflict} !== {1'b1, 5'd5, 32'h1234, 1'b0})
      begin fails++; $display("FAIL single_write: got we=%b wa=%0d wd=%h c=%b exp 1/5/1234/0", we, wa, wd, conflict); end
    r[0] = '{addr: 5'd1, data: 32'h11};
    r[2] = '{addr: 5'd3, data: 32'h33};
    drive(3'b111, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b100) begin fails++; $display("FAIL single_ptr2: got %b exp 100", req_ready); end
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) r[i] = '{addr: 5'(i + 10), data: $urandom};
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, 1'b0, 1'b0);
      tests++;
      if (req_ready !== (3'b001 << (c % 3)))
        begin fails++; $display("FAIL rr_grant%0d: got %b exp %b", c, req_ready, 3'b001 << (c % 3)); end
      tick();
      tests++;
      if ({we, wa, wd, conflict} !== {1'b1, r[c % 3].addr, r[c % 3].data, 1'b1})
        begin fails++; $display("FAIL rr_write%0d: got we=%b wa=%0d wd=%h c=%b exp wa=%0d wd=%h", c, we, wa, wd, conflict, r[c % 3].addr, r[c % 3].data); end
    end
  endtask

  task automatic test_hold();
    int p = ptr_m;
    drive(3'b010, 1'b0, 1'b0);
    tick();
    p = ptr_m;
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, 1'b1, 1'b0);
      tests++;
      if (req_ready !== 3'b000) begin fails++; $display("FAIL hold_ready%0d: got %b exp 000", c, req_ready); end
      tick();
      tests++;
      if (we !== 1'b0 || conflict !== 1'b0) begin fails++; $display("FAIL hold_we%0d: got we=%b c=%b exp 0/0", c, we, conflict); end
    end
    drive(3'b111, 1'b0, 1'b0);
    tests++;
    if (req_ready !== (3'b001 << p)) begin fails++; $display("FAIL hold_resume: got %b exp %b", req_ready, 3'b001 << p); end
    tick();
  endtask

  task automatic test_same_addr();
    r[2] = '{addr: 5'd9, data: 32'h99};
    drive(3'b100, 1'b0, 1'b0);
    tick();
    r[0] = '{addr: 5'd7, data: 32'hA};
    r[2] = '{addr: 5'd7, data: 32'hB};
    drive(3'b101, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b001) begin fails++; $display("FAIL same_first: got %b exp 001", req_ready); end
    tick();
    tests++;
    if ({we, wa, wd} !== {1'b1, 5'd7, 32'hA}) begin fails++; $display("FAIL same_write_a: got we=%b wa=%0d wd=%h exp 1/7/a", we, wa, wd); end
    drive(3'b100, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b100) begin fails++; $display("FAIL same_second: got %b exp 100", req_ready); end
    tick();
    tests++;
    if (rf_dut[7] !== 32'hB) begin fails++; $display("FAIL same_final: got x7=%h exp b", rf_dut[7]); end
  endtask

`ifdef RFARB_X0_DROP_EN
  task automatic test_x0();
    r[2] = '{addr: 5'd4, data: 32'h44};
    drive(3'b100, 1'b0, 1'b0);
    tick();
    r[0] = '{addr: 5'd0, data: 32'hDEAD};
    r[1] = '{addr: 5'd3, data: 32'h3333};
    drive(3'b011, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b011) begin fails++; $display("FAIL x0_ready: got %b exp 011", req_ready); end
    tick();
    tests++;
    if ({we, wa, wd, conflict} !== {1'b1, 5'd3, 32'h3333, 1'b0})
      begin fails++; $display("FAIL x0_write: got we=%b wa=%0d wd=%h c=%b exp 1/3/3333/0", we, wa, wd, conflict); end
    drive(3'b111, 1'b0, 1'b0);
    tests++;
    if (req_ready !== 3'b101) begin fails++; $display("FAIL x0_ptr2: got %b exp 101", req_ready); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [2:0] pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i] = 1'b1;
          r[i] = '{addr: 5'($urandom % 32), data: $urandom};
        end
      end
      drive(pend, ($urandom % 6) == 0, ($urandom % 40) == 0);
      tests++;
      if (req_ready !== e_ready) begin fails++; $display("FAIL rand_ready%0d: got %b exp %b", c, req_ready, e_ready); end
      tick();
      tests++;
      if ({we, wa, wd, conflict} !== {e_we, e_wa, e_wd, e_conf})
        begin fails++; $display("FAIL rand_out%0d: got %b/%0d/%h/%b exp %b/%0d/%h/%b", c, we, wa, wd, conflict, e_we, e_wa, e_wd, e_conf); end
      pend = pend & ~e_ready;
    end
  endtask

  initial begin
    ptr_m = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_same_addr();
`ifdef RFARB_X0_DROP_EN
    test_x0();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
